// File: rtl/axi_llc_pkg.sv
// Shared helpers and payload layout for the LLC SRAM bank slice.
package axi_llc_pkg;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Bank request payload field order: {we, addr, wdata, be}.
  // Bank response payload field order: {chan, err, data}.
  // Field widths follow the bank parameters, so the structs are declared
  // where those widths are known (see axi_llc_sram_hs_bank).

endpackage

// File: rtl/axi_llc_rr_arb.sv
// Round-robin arbiter; the priority pointer advances past the winner only on a grant.
module axi_llc_rr_arb
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumIn = 2,
  localparam int unsigned IdxWidth = idx_width(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumIn-1:0]    valid_i,
  output logic [NumIn-1:0]    gnt_c,
  output logic [IdxWidth-1:0] idx_c
);

  logic [IdxWidth-1:0] ptr_q;

  // Scan from the pointer, first eligible requester wins.
  always_comb begin
    logic                found;
    logic [IdxWidth-1:0] cand;
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = IdxWidth'((32'(ptr_q) + i) % NumIn);
      if (!found && valid_i[cand]) begin
        found        = 1'b1;
        gnt_c[cand]  = 1'b1;
        idx_c        = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (|gnt_c) begin
      ptr_q <= IdxWidth'((32'(idx_c) + 32'd1) % NumIn);
    end
  end

endmodule

// File: rtl/axi_llc_tc_sram.sv
// Behavioural 1..N-port SRAM macro with fixed read latency; rdata holds on writes.
module axi_llc_tc_sram #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  logic [DataWidth-1:0]                       mem_q [NumWords];
  logic [Latency-1:0][NumPorts-1:0][DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (req_i[p] && we_i[p]) begin
        for (int unsigned b = 0; b < BeWidth; b++) begin
          if (be_i[p][b]) begin
            mem_q[addr_i[p]][b*ByteWidth +: ByteWidth] <= wdata_i[p][b*ByteWidth +: ByteWidth];
          end
        end
      end
    end
  end

  // Stage 0 captures only on reads; later stages just carry it to the output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (req_i[p] && !we_i[p]) rdata_q[0][p] <= mem_q[addr_i[p]];
      end
      for (int unsigned i = 1; i < Latency; i++) rdata_q[i] <= rdata_q[i-1];
    end
  end

  assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/axi_llc_sram_hs_bank.sv
// Multi-channel valid/ready front end for a single-port SRAM bank with credited,
// backpressurable read responses tagged by originating channel.
module axi_llc_sram_hs_bank
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned Latency     = 1,
  parameter int unsigned RspDepth    = 2,
  localparam int unsigned ChanIdxWidth = idx_width(NumChannels),
  localparam int unsigned AddrWidth    = idx_width(NumWords),
  localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                req_valid_i,
  output logic [NumChannels-1:0]                req_ready_o,
  input  logic [NumChannels-1:0]                req_we_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] req_wdata_i,
  input  logic [NumChannels-1:0][BeWidth-1:0]   req_be_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [ChanIdxWidth-1:0]               rsp_chan_o,
  output logic [DataWidth-1:0]                  rsp_data_o,
  output logic                                  rsp_err_o,
  output logic                                  busy_o
);

  localparam int unsigned CntWidth = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth = idx_width(RspDepth);

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } bank_req_t;

  typedef struct packed {
    logic [ChanIdxWidth-1:0] chan;
    logic                    err;
    logic [DataWidth-1:0]    data;
  } bank_rsp_t;

  logic [NumChannels-1:0]  elig;
  logic [ChanIdxWidth-1:0] gnt_idx;
  bank_req_t               sel;
  logic                    accept, rd_accept, in_range, sram_req, credit_ok;
  logic [DataWidth-1:0]    sram_rdata;

  logic [CntWidth-1:0]     cnt_q, fcnt_q;
  logic [PtrWidth-1:0]     wptr_q, rptr_q;
  bank_rsp_t               fifo_q [RspDepth];
  bank_rsp_t               head, push_entry;
  logic                    push, pop;

  logic [Latency-1:0]                   trk_valid_q, trk_err_q;
  logic [Latency-1:0][ChanIdxWidth-1:0] trk_chan_q;

  // Reads need a free response slot; writes never produce a response.
  assign credit_ok = (cnt_q < CntWidth'(RspDepth));
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      elig[i] = !rst_i && req_valid_i[i] && (req_we_i[i] || credit_ok);
    end
  end

  axi_llc_rr_arb #(.NumIn(NumChannels)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (elig),
    .gnt_c   (req_ready_o),
    .idx_c   (gnt_idx)
  );

  always_comb begin
    sel = '{we:    req_we_i[gnt_idx],
            addr:  req_addr_i[gnt_idx],
            wdata: req_wdata_i[gnt_idx],
            be:    req_be_i[gnt_idx]};
  end

  assign accept    = |req_ready_o;
  assign rd_accept = accept && !sel.we;
  assign in_range  = (32'(sel.addr) < NumWords);
  assign sram_req  = accept && in_range;

  axi_llc_tc_sram #(
    .NumWords  (NumWords),
    .DataWidth (DataWidth),
    .ByteWidth (ByteWidth),
    .NumPorts  (1),
    .Latency   (Latency)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .req_i   (sram_req),
    .we_i    (sel.we),
    .addr_i  (sel.addr),
    .wdata_i (sel.wdata),
    .be_i    (sel.be),
    .rdata_o (sram_rdata)
  );

  // Read tracker aligned with the macro latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_valid_q <= '0;
      trk_err_q   <= '0;
      trk_chan_q  <= '0;
    end else begin
      trk_valid_q[0] <= rd_accept;
      trk_err_q[0]   <= !in_range;
      trk_chan_q[0]  <= gnt_idx;
      for (int unsigned i = 1; i < Latency; i++) begin
        trk_valid_q[i] <= trk_valid_q[i-1];
        trk_err_q[i]   <= trk_err_q[i-1];
        trk_chan_q[i]  <= trk_chan_q[i-1];
      end
    end
  end

  assign push = trk_valid_q[Latency-1];
  assign pop  = rsp_valid_o && rsp_ready_i;
  assign push_entry = '{chan: trk_chan_q[Latency-1],
                        err:  trk_err_q[Latency-1],
                        data: trk_err_q[Latency-1] ? '0 : sram_rdata};

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wptr_q + PtrWidth'(1);
      if (pop)  rptr_q <= (rptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rptr_q + PtrWidth'(1);
      if (push && !pop)      fcnt_q <= fcnt_q + CntWidth'(1);
      else if (pop && !push) fcnt_q <= fcnt_q - CntWidth'(1);
      if (rd_accept && !pop)      cnt_q <= cnt_q + CntWidth'(1);
      else if (pop && !rd_accept) cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  // Head fields are forced to zero whenever no response is presented.
  assign head        = fifo_q[rptr_q];
  assign rsp_valid_o = (fcnt_q != '0);
  assign rsp_chan_o  = rsp_valid_o ? head.chan : '0;
  assign rsp_err_o   = rsp_valid_o ? head.err  : 1'b0;
  assign rsp_data_o  = rsp_valid_o ? head.data : '0;
  assign busy_o      = (|trk_valid_q) || rsp_valid_o;

endmodule
